// File: rtl/trivium_ctrl.sv
// trivium_ctrl
// Sequencer for a Trivium keystream core. A start request loads key/IV into
// the core, runs the warm-up steps with their output discarded, then clocks the
// core and packs keystream bits (LSB first) into bytes. Bytes leave over a
// valid/ready handshake. The core is throttled whenever the consumer stalls.
//
// Parameters:
//   WARMUP  core steps discarded after load (default 1152 = 4 x 288)
//   LEN_W   width of the byte-count input
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start, len           begin a session of len bytes (sampled only in IDLE)
//   key, iv              80-bit key / IV, passed straight through to the core
//   core_load            one-cycle load strobe to the core
//   core_en              core step enable
//   core_key, core_iv    combinational copies of key / iv
//   core_ks_bit          keystream bit of the current core step
//   ks_byte, ks_valid    output byte and its valid flag
//   ks_ready             consumer accepts ks_byte
//   busy                 high whenever the sequencer is not idle
//   done                 one-cycle pulse after the last byte is accepted
//
// Optional build macro TRIVIUM_CTRL_XOR_EN: adds din[7:0] / din_valid.
// ks_byte then becomes keystream XOR din, and a byte only moves to the output
// register while din_valid is high, which turns the block into a stream
// encrypt/decrypt engine.

module trivium_ctrl #(
  parameter int WARMUP = 1152,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
`ifdef TRIVIUM_CTRL_XOR_EN
  input  logic [7:0]       din,
  input  logic             din_valid,
`endif
  output logic             core_load,
  output logic             core_en,
  output logic [79:0]      core_key,
  output logic [79:0]      core_iv,
  input  logic             core_ks_bit,
  output logic [7:0]       ks_byte,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done
);

  localparam int            CW        = $clog2(WARMUP + 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_GEN
  } state_t;

  state_t           state;
  logic [CW-1:0]    warm_cnt;
  logic [LEN_W-1:0] remain;
  logic [7:0]       shreg;
  logic [3:0]       bit_cnt;

  logic       sr_full;
  logic       accept;
  logic       can_xfer;
  logic       byte_done;
  logic       xfer;
  logic [7:0] next_byte;
  logic [7:0] out_byte;

  assign core_key = key;
  assign core_iv  = iv;

  // remain counts bytes not yet moved to the output register, including the
  // one being assembled. bit_cnt==8 means a complete byte is parked in shreg
  // because the output register could not take it. The eighth bit of a byte
  // is forwarded straight into the output register on the same edge it is
  // captured, so an unstalled stream never needs the parked state and has no
  // bubbles.
  always_comb begin
    sr_full  = (bit_cnt == 4'd8);
    accept   = ks_valid && ks_ready;
`ifdef TRIVIUM_CTRL_XOR_EN
    can_xfer = (!ks_valid || ks_ready) && din_valid;
`else
    can_xfer = !ks_valid || ks_ready;
`endif
    core_en = 1'b0;
    if (state == S_WARM) begin
      core_en = 1'b1;
    end else if (state == S_GEN) begin
      // A parked byte blocks the core unless it leaves this cycle. If it is
      // the final byte, every bit has already been collected.
      core_en = (remain != '0) &&
                !(sr_full && (!can_xfer || remain == LEN_W'(1)));
    end
    byte_done = sr_full || (core_en && bit_cnt == 4'd7);
    xfer      = (state == S_GEN) && byte_done && can_xfer;
    next_byte = sr_full ? shreg : {core_ks_bit, shreg[7:1]};
`ifdef TRIVIUM_CTRL_XOR_EN
    out_byte  = next_byte ^ din;
`else
    out_byte  = next_byte;
`endif
  end

  // Session sequencer with registered strobes and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      warm_cnt  <= '0;
      remain    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      ks_byte   <= '0;
      ks_valid  <= 1'b0;
      core_load <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      core_load <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && len != '0) begin
            state     <= S_LOAD;
            remain    <= len;
            bit_cnt   <= '0;
            core_load <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          state    <= S_WARM;
          warm_cnt <= '0;
        end
        S_WARM: begin
          if (warm_cnt == WARM_LAST) begin
            state <= S_GEN;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_GEN: begin
          // Shift right so that the first bit of a byte ends up in bit 0.
          if (core_en) begin
            shreg <= {core_ks_bit, shreg[7:1]};
          end
          if (xfer) begin
            ks_byte  <= out_byte;
            ks_valid <= 1'b1;
            remain   <= remain - 1'b1;
            // Leaving the parked state while the core steps again means the
            // next byte has already received its first bit.
            bit_cnt  <= (sr_full && core_en) ? 4'd1 : 4'd0;
          end else begin
            if (core_en) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (accept) begin
              ks_valid <= 1'b0;
            end
          end
          // With remain at zero the output register holds the last byte.
          if (accept && remain == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Self-checking bench for trivium_ctrl. A behavioural Trivium core is attached
// to the core_* ports. Expected keystream bytes come from a separate
// software run of the same cipher, with warm-up and byte packing done directly
// in the bench. Session timing expectations are hand-derived constants.

module tb_trivium_ctrl;

  localparam int          LEN_W  = 16;
  localparam int          WARMUP = 1152;
  localparam logic [79:0] KEY    = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] IV     = 80'hECBB76B09AFF71D0D151;
`ifdef TRIVIUM_CTRL_XOR_EN
  localparam logic [7:0]  XMASK  = 8'hFF;
`else
  localparam logic [7:0]  XMASK  = 8'h00;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [79:0]      key;
  logic [79:0]      iv;
  logic             core_load;
  logic             core_en;
  logic [79:0]      core_key;
  logic [79:0]      core_iv;
  logic             core_ks_bit;
  logic [7:0]       ks_byte;
  logic             ks_valid;
  logic             ks_ready;
  logic             busy;
  logic             done;
`ifdef TRIVIUM_CTRL_XOR_EN
  logic [7:0]       din;
  logic             din_valid;
`endif

  trivium_ctrl #(.WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .key         (key),
    .iv          (iv),
`ifdef TRIVIUM_CTRL_XOR_EN
    .din         (din),
    .din_valid   (din_valid),
`endif
    .core_load   (core_load),
    .core_en     (core_en),
    .core_key    (core_key),
    .core_iv     (core_iv),
    .core_ks_bit (core_ks_bit),
    .ks_byte     (ks_byte),
    .ks_valid    (ks_valid),
    .ks_ready    (ks_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Trivium cipher helpers (state bits numbered 1..288).
  function automatic logic [288:1] trivInit(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    s = '0;
    for (int i = 0; i < 80; i++) begin
      s[i + 1]  = k[i];
      s[i + 94] = v[i];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    return s;
  endfunction

  function automatic logic trivZ(input logic [288:1] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [288:1] trivStep(input logic [288:1] s);
    logic         t1, t2, t3;
    logic [288:1] n;
    t1 = s[66]  ^ s[93]  ^ (s[91]  & s[92])  ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n = s;
    n[93:1]    = {s[92:1], t3};
    n[177:94]  = {s[176:94], t1};
    n[288:178] = {s[287:178], t2};
    return n;
  endfunction

  // Behavioural keystream core driven by the controller.
  logic [288:1] coreState = '0;
  always @(posedge clk) begin
    if (core_load) coreState <= trivInit(core_key, core_iv);
    else if (core_en) coreState <= trivStep(coreState);
  end
  assign core_ks_bit = trivZ(coreState);

  typedef struct {
    int len;
    int readyLo;
    int readyHi;
    int poke;
    int expFirst;
    int expDone;
    int expEn;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] refBytes [16];
  logic [7:0] gotBytes [32];

  int checks = 0;
  int errors = 0;
  int nGot, firstC, doneC, nEn, nLoad, stableErr, busyErr;
  logic doneBusy;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Runs one session and records what the DUT did. Cycle numbers count from
  // the edge that samples start (LOAD is cycle 1). ks_ready is low for cycles
  // readyLo..readyHi. start is pulsed again in cycle poke. When abort is
  // reached, reset is raised in that cycle and the task returns with reset
  // still asserted.
  task automatic applyStimulus(input int l, input int lo, input int hi,
                               input int poke, input int abort);
    int         cyc;
    logic       pend;
    logic [7:0] pbyte;
    nGot = 0; firstC = -1; doneC = -1; nEn = 0; nLoad = 0;
    stableErr = 0; busyErr = 0; doneBusy = 1'b1;
    pend = 1'b0; pbyte = '0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(l); ks_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      @(negedge clk);
      ks_ready = !(cyc >= lo && cyc <= hi);
      start    = (cyc == poke);
      if (cyc == poke) len = LEN_W'(5);
      if (cyc == abort) begin
        rst = 1'b1;
        #1;
        break;
      end
      #1;
      if (core_load) nLoad++;
      if (core_en) nEn++;
      if (!done && busy !== 1'b1) busyErr++;
      if (pend && ks_byte !== pbyte) stableErr++;
      if (ks_valid && firstC < 0) firstC = cyc;
      if (ks_valid && ks_ready) begin
        if (nGot < 32) gotBytes[nGot] = ks_byte;
        nGot++;
        pend = 1'b0;
      end else begin
        pend  = ks_valid;
        pbyte = ks_byte;
      end
      if (done) begin
        doneC    = cyc;
        doneBusy = busy;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic checkSession(input int v);
    string p;
    p = $sformatf("vec%0d", v);
    checkOutput({p, "_first_valid_cycle"}, firstC, vecs[v].expFirst);
    checkOutput({p, "_done_cycle"}, doneC, vecs[v].expDone);
    checkOutput({p, "_core_en_cycles"}, nEn, vecs[v].expEn);
    checkOutput({p, "_core_load_count"}, nLoad, 1);
    checkOutput({p, "_bytes_delivered"}, nGot, vecs[v].len);
    checkOutput({p, "_byte_hold_violations"}, stableErr, 0);
    checkOutput({p, "_busy_drop_early"}, busyErr, 0);
    checkOutput({p, "_busy_at_done"}, doneBusy, 0);
    for (int b = 0; b < vecs[v].len; b++)
      checkOutput($sformatf("%s_byte%0d", p, b), gotBytes[b], refBytes[b] ^ XMASK);
    @(posedge clk);
    #1;
    checkOutput({p, "_done_pulse_width"}, done, 0);
  endtask

  initial begin
    logic [288:1] s;
    int           loads, busySeen;

    // Reference keystream: warm-up discarded, bits packed LSB first.
    s = trivInit(KEY, IV);
    repeat (WARMUP) s = trivStep(s);
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 8; i++) begin
        refBytes[b][i] = trivZ(s);
        s = trivStep(s);
      end
    end

    vecs[0] = '{16, 0,    -1,   -1,  1162, 1283, 1280};
    vecs[1] = '{16, 1162, 1200, -1,  1162, 1314, 1280};
    vecs[2] = '{1,  0,    -1,   100, 1162, 1163, 1160};
    vecs[3] = '{2,  1162, 1175, -1,  1162, 1178, 1168};

    rst = 1'b1; start = 1'b0; len = '0; ks_ready = 1'b0; key = KEY; iv = IV;
`ifdef TRIVIUM_CTRL_XOR_EN
    din = 8'hFF; din_valid = 1'b1;
`endif
    #1;
    checkOutput("reset_outputs", {core_load, core_en, ks_valid, busy, done, ks_byte}, 0);
    checkOutput("core_key_passthrough", core_key == KEY, 1);
    checkOutput("core_iv_passthrough", core_iv == IV, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] table-driven sessions");
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].len, vecs[v].readyLo, vecs[v].readyHi, vecs[v].poke, -1);
      checkSession(v);
    end

    $display("[TB] start with len=0");
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    loads = 0; busySeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (core_load) loads++;
      if (busy) busySeen++;
    end
    checkOutput("len0_core_load_count", loads, 0);
    checkOutput("len0_busy_cycles", busySeen, 0);

    $display("[TB] reset during warm-up");
    applyStimulus(16, 0, -1, -1, 600);
    checkOutput("abort_outputs_in_reset", {core_load, core_en, ks_valid, busy, done, ks_byte}, 0);
    checkOutput("abort_core_en_before_reset", nEn, 598);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(vecs[0].len, vecs[0].readyLo, vecs[0].readyHi, vecs[0].poke, -1);
    checkSession(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
